// File: rtl/stage1_fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Defines the fetch FSM encoding, debug status codes and the bubble instruction.
package stage1_fetch_pkg;

  typedef logic [31:0] Addr;
  typedef logic [31:0] Data;
  typedef logic        Bool;
  typedef logic        Clock;

  typedef logic [2:0] FetchState;
  localparam FetchState FS_IDLE = 3'd0;
  localparam FetchState FS_REQ  = 3'd1;
  localparam FetchState FS_WAIT = 3'd2;
  localparam FetchState FS_BUF  = 3'd3;
  localparam FetchState FS_HALT = 3'd4;

  typedef logic DebugStatus;
  localparam DebugStatus DBG_OK         = 1'b0;
  localparam DebugStatus DBG_MISALIGNED = 1'b1;

  // addi x0,x0,0
  localparam Data NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/stage1_fetch.sv
// stage1_fetch: owns the fetch PC, keeps one imem request in flight and
// buffers one response that lands while decode is stalled.
// Ports: clk, reset (async, active-high); stall_in from decode;
//   jump_enable_in/jump_address_in redirect from execute;
//   imem_req_out/imem_addr_out/imem_gnt_in/imem_rvalid_in/imem_rdata_in;
//   instruction_out/pc_out/discard_out to decode; debug_out status.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect target
//   reports MISALIGNED on debug_out and parks the stage in HALT.
module stage1_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = stage1_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        jump_enable_in,
  input  logic [31:0] jump_address_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        discard_out,
  output logic        debug_out
);

  import stage1_fetch_pkg::*;

  FetchState state_q, state_d;
  Addr       fetch_pc_q, fetch_pc_d;
  Bool       kill_q, kill_d;
  Data       buf_q, buf_d;
  Addr       buf_pc_q, buf_pc_d;
  Data       instr_q, instr_d;
  Addr       pc_q, pc_d;
  Bool       discard_q, discard_d;
  Bool       hold;
  Bool       misalign;

  // Decode asserts stall during its own bubble; ignore it then.
  assign hold = stall_in && !discard_q;

  assign imem_req_out    = (state_q == FS_REQ);
  assign imem_addr_out   = fetch_pc_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_q;
  assign discard_out     = discard_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  DebugStatus dbg_q, dbg_d;
  assign misalign  = jump_enable_in && (jump_address_in[1:0] != 2'b00);
  assign debug_out = dbg_q;
`else
  assign misalign  = 1'b0;
  assign debug_out = DBG_OK;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    dbg_d      = dbg_q;
`endif

    if (!hold) begin
      instr_d   = NOP_INSTR;
      discard_d = 1'b1;
    end
    if (jump_enable_in) begin
      instr_d    = NOP_INSTR;
      discard_d  = 1'b1;
      fetch_pc_d = jump_address_in;
    end

    unique case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        if (imem_gnt_in) begin
          state_d = FS_WAIT;
          // Granted address is stale if a redirect lands now.
          kill_d  = jump_enable_in;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid_in) begin
          if (kill_q || jump_enable_in) begin
            kill_d  = 1'b0;
            state_d = FS_REQ;
          end else if (hold) begin
            buf_d    = imem_rdata_in;
            buf_pc_d = fetch_pc_q;
            state_d  = FS_BUF;
          end else begin
            instr_d    = imem_rdata_in;
            pc_d       = fetch_pc_q;
            discard_d  = 1'b0;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = FS_REQ;
          end
        end else if (jump_enable_in) begin
          kill_d = 1'b1;
        end
      end
      FS_BUF: begin
        if (jump_enable_in) begin
          state_d = FS_REQ;
        end else if (!hold) begin
          instr_d    = buf_q;
          pc_d       = buf_pc_q;
          discard_d  = 1'b0;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = FS_REQ;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      FS_HALT: state_d = FS_HALT;
`endif
      default: state_d = FS_IDLE;
    endcase

`ifdef FETCH_MISALIGN_CHECK_EN
    if (misalign) begin
      state_d = FS_HALT;
      kill_d  = 1'b0;
      dbg_d   = DBG_MISALIGNED;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      buf_q      <= '0;
      buf_pc_q   <= '0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      discard_q  <= 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      dbg_q      <= DBG_OK;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      dbg_q      <= dbg_d;
`endif
    end
  end

endmodule

// File: tb/tb_stage1_fetch.sv
// Self-checking bench for stage1_fetch: directed timing scenarios plus a
// randomized run scored against a program-order instruction stream model.
module tb_stage1_fetch;
  import stage1_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        jump_enable_in;
  logic [31:0] jump_address_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        discard_out;
  logic        debug_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_addr;
  int          gnt_pct;
  int          lat_min;
  int          lat_max;

  // Snapshot of the cycle most recently driven
  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  logic        s_disc;
  logic        s_dbg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  stage1_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .jump_enable_in  (jump_enable_in),
    .jump_address_in (jump_address_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_gnt_in     (imem_gnt_in),
    .imem_rvalid_in  (imem_rvalid_in),
    .imem_rdata_in   (imem_rdata_in),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .discard_out     (discard_out),
    .debug_out       (debug_out)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // Called at a negedge: drive one cycle of inputs, sample, advance.
  task automatic cyc(input logic st, input logic jmp,
                     input logic [31:0] tgt);
    stall_in        = st;
    jump_enable_in  = jmp;
    jump_address_in = tgt;
    imem_gnt_in     = 1'b0;
    imem_rvalid_in  = 1'b0;
    imem_rdata_in   = 32'h0;
    if (m_pend) begin
      if (m_cnt <= 1) begin
        imem_rvalid_in = 1'b1;
        imem_rdata_in  = memf(m_addr);
        m_pend         = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (imem_req_out &&
                 (int'($urandom_range(99)) < gnt_pct)) begin
      imem_gnt_in = 1'b1;
      m_pend      = 1'b1;
      m_addr      = imem_addr_out;
      m_cnt       = int'($urandom_range(lat_max, lat_min));
    end
    #1;
    s_req   = imem_req_out;
    s_addr  = imem_addr_out;
    s_instr = instruction_out;
    s_pc    = pc_out;
    s_disc  = discard_out;
    s_dbg   = debug_out;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    stall_in        = 1'b0;
    jump_enable_in  = 1'b0;
    jump_address_in = 32'h0;
    imem_gnt_in     = 1'b0;
    imem_rvalid_in  = 1'b0;
    imem_rdata_in   = 32'h0;
    m_pend          = 1'b0;
    m_cnt           = 0;
    gnt_pct         = 100;
    lat_min         = 1;
    lat_max         = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lat_min = 3;
    lat_max = 3;
    cyc(0, 0, 32'h0);
    cyc(0, 0, 32'h0);
    // Now in WAIT with a request outstanding; reset asynchronously.
    #2;
    reset = 1'b1;
    #1;
    m_pend = 1'b0;
    n_cmp++;
    if (imem_req_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_req got=%b exp=0", imem_req_out);
    end
    n_cmp++;
    if (instruction_out !== NOP) begin
      n_bad++;
      $display("FAIL reset_instr got=%h exp=%h", instruction_out, NOP);
    end
    n_cmp++;
    if (pc_out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_pc got=%h exp=0", pc_out);
    end
    n_cmp++;
    if (discard_out !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_discard got=%b exp=1", discard_out);
    end
    n_cmp++;
    if (debug_out !== DBG_OK) begin
      n_bad++;
      $display("FAIL reset_debug got=%b exp=%b", debug_out, DBG_OK);
    end
    @(negedge clk);
    reset   = 1'b0;
    lat_min = 1;
    lat_max = 1;
    cyc(0, 0, 32'h0);
    cyc(0, 0, 32'h0);
    n_cmp++;
    if ({s_req, s_addr} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_restart req=%b addr=%h exp req=1 addr=0",
               s_req, s_addr);
    end
  endtask

  task automatic test_zero_wait();
    logic        er;
    logic        ed;
    logic [31:0] ea;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 32'h0);
      er = (i % 2) == 1;
      ed = !(i >= 3 && (i % 2) == 1);
      n_cmp++;
      if (s_req !== er) begin
        n_bad++;
        $display("FAIL zw_req[%0d] got=%b exp=%b", i, s_req, er);
      end
      if (er) begin
        ea = 32'(2 * (i - 1));
        n_cmp++;
        if (s_addr !== ea) begin
          n_bad++;
          $display("FAIL zw_addr[%0d] got=%h exp=%h", i, s_addr, ea);
        end
      end
      n_cmp++;
      if (s_disc !== ed) begin
        n_bad++;
        $display("FAIL zw_disc[%0d] got=%b exp=%b", i, s_disc, ed);
      end
      if (!ed) begin
        ea = 32'(2 * (i - 3));
        n_cmp++;
        if ({s_pc, s_instr} !== {ea, memf(ea)}) begin
          n_bad++;
          $display("FAIL zw_out[%0d] pc=%h ins=%h exp pc=%h ins=%h",
                   i, s_pc, s_instr, ea, memf(ea));
        end
      end
    end
  endtask

  task automatic test_stall_buf();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc((i >= 5 && i <= 7), 0, 32'h0);
      if (i >= 5 && i <= 8) begin
        n_cmp++;
        if ({s_disc, s_pc, s_instr} !== {1'b0, 32'h4, memf(32'h4)}) begin
          n_bad++;
          $display("FAIL sb_hold[%0d] disc=%b pc=%h exp disc=0 pc=4",
                   i, s_disc, s_pc);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if ({s_disc, s_pc, s_instr} !== {1'b0, 32'h8, memf(32'h8)}) begin
          n_bad++;
          $display("FAIL sb_deliver disc=%b pc=%h ins=%h exp pc=8",
                   s_disc, s_pc, s_instr);
        end
        n_cmp++;
        if ({s_req, s_addr} !== {1'b1, 32'hC}) begin
          n_bad++;
          $display("FAIL sb_nextreq req=%b addr=%h exp req=1 addr=c",
                   s_req, s_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        lat_min = 1;
        lat_max = 1;
      end
      cyc(0, (i == 2), 32'h100);
      if (i >= 2 && i <= 6) begin
        n_cmp++;
        if (s_disc !== 1'b1) begin
          n_bad++;
          $display("FAIL rw_disc[%0d] got=%b exp=1", i, s_disc);
        end
      end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (s_req !== 1'b0) begin
          n_bad++;
          $display("FAIL rw_noreq[%0d] got=%b exp=0", i, s_req);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if ({s_req, s_addr} !== {1'b1, 32'h100}) begin
          n_bad++;
          $display("FAIL rw_req req=%b addr=%h exp req=1 addr=100",
                   s_req, s_addr);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if ({s_disc, s_pc, s_instr} !== {1'b0, 32'h100, memf(32'h100)}) begin
          n_bad++;
          $display("FAIL rw_out disc=%b pc=%h ins=%h exp pc=100",
                   s_disc, s_pc, s_instr);
        end
      end
    end
  endtask

  task automatic test_redirect_gnt_rvalid();
    logic        j;
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      j = (i == 1) || (i == 4);
      t = (i == 1) ? 32'h200 : 32'h300;
      cyc(0, j, t);
      if (i >= 1 && i <= 6) begin
        n_cmp++;
        if (s_disc !== 1'b1) begin
          n_bad++;
          $display("FAIL rg_disc[%0d] got=%b exp=1", i, s_disc);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (s_req !== 1'b0) begin
          n_bad++;
          $display("FAIL rg_wait got=%b exp=0", s_req);
        end
      end
      if (i == 3 || i == 5) begin
        t = (i == 3) ? 32'h200 : 32'h300;
        n_cmp++;
        if ({s_req, s_addr} !== {1'b1, t}) begin
          n_bad++;
          $display("FAIL rg_req[%0d] req=%b addr=%h exp addr=%h",
                   i, s_req, s_addr, t);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if ({s_disc, s_pc, s_instr} !== {1'b0, 32'h300, memf(32'h300)}) begin
          n_bad++;
          $display("FAIL rg_out disc=%b pc=%h ins=%h exp pc=300",
                   s_disc, s_pc, s_instr);
        end
      end
    end
  endtask

  task automatic test_stall_discard();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h0);
      if (i == 1) begin
        n_cmp++;
        if ({s_req, s_addr} !== {1'b1, 32'h0}) begin
          n_bad++;
          $display("FAIL sd_req req=%b addr=%h exp req=1 addr=0",
                   s_req, s_addr);
        end
      end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if ({s_disc, s_pc, s_instr} !== {1'b0, 32'h0, memf(32'h0)}) begin
          n_bad++;
          $display("FAIL sd_out[%0d] disc=%b pc=%h exp disc=0 pc=0",
                   i, s_disc, s_pc);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (s_req !== 1'b0) begin
          n_bad++;
          $display("FAIL sd_noreq got=%b exp=0", s_req);
        end
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    cyc(0, 1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 1; i < 6; i++) begin
      cyc(0, 0, 32'h0);
      n_cmp++;
      if ({s_dbg, s_req, s_disc} !== {DBG_MISALIGNED, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL ma_halt[%0d] dbg=%b req=%b disc=%b exp 1/0/1",
                 i, s_dbg, s_req, s_disc);
      end
    end
    do_reset();
    cyc(0, 0, 32'h0);
    n_cmp++;
    if (s_dbg !== DBG_OK) begin
      n_bad++;
      $display("FAIL ma_dbgclr got=%b exp=%b", s_dbg, DBG_OK);
    end
    cyc(0, 0, 32'h0);
    n_cmp++;
    if ({s_req, s_addr} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL ma_restart req=%b addr=%h exp req=1 addr=0",
               s_req, s_addr);
    end
`else
    cyc(0, 0, 32'h0);
    n_cmp++;
    if ({s_dbg, s_req, s_addr} !== {DBG_OK, 1'b1, 32'h102}) begin
      n_bad++;
      $display("FAIL ma_pass dbg=%b req=%b addr=%h exp 0/1/102",
               s_dbg, s_req, s_addr);
    end
    cyc(0, 0, 32'h0);
    cyc(0, 0, 32'h0);
    n_cmp++;
    if ({s_disc, s_pc, s_instr} !== {1'b0, 32'h102, memf(32'h102)}) begin
      n_bad++;
      $display("FAIL ma_out disc=%b pc=%h exp pc=102", s_disc, s_pc);
    end
`endif
  endtask

  // Reference: consumed instructions form the program-order stream
  // starting at RESET_PC, stepping by 4 and restarting at each target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        st;
    logic        jmp;
    logic [31:0] tgt;
    logic        p_st;
    logic        p_jmp;
    logic [31:0] p_instr;
    logic [31:0] p_pc;
    logic        p_disc;
    int          consumed;
    do_reset();
    gnt_pct  = 70;
    lat_min  = 1;
    lat_max  = 3;
    exp_pc   = 32'h0;
    consumed = 0;
    p_st     = 1'b0;
    p_jmp    = 1'b0;
    p_instr  = 32'h0;
    p_pc     = 32'h0;
    p_disc   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(99) < 30);
      jmp = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0)
        tgt = 32'hFFFF_FFF0 | {28'h0, 2'($urandom_range(3)), 2'b00};
      else
        tgt = $urandom & 32'hFFFF_FFFC;
      cyc(st, jmp, tgt);
      if (i > 0) begin
        if (p_jmp) begin
          n_cmp++;
          if ({s_disc, s_instr} !== {1'b1, NOP}) begin
            n_bad++;
            $display("FAIL rnd_jmpbubble[%0d] disc=%b ins=%h", i,
                     s_disc, s_instr);
          end
        end else if (p_st && !p_disc) begin
          n_cmp++;
          if ({s_instr, s_pc, s_disc} !== {p_instr, p_pc, p_disc}) begin
            n_bad++;
            $display("FAIL rnd_hold[%0d] pc=%h disc=%b exp pc=%h disc=0",
                     i, s_pc, s_disc, p_pc);
          end
        end
      end
      n_cmp++;
      if (s_disc && s_instr !== NOP) begin
        n_bad++;
        $display("FAIL rnd_nop[%0d] ins=%h exp=%h", i, s_instr, NOP);
      end else if (!s_disc && s_instr !== memf(s_pc)) begin
        n_bad++;
        $display("FAIL rnd_data[%0d] ins=%h exp=%h", i, s_instr,
                 memf(s_pc));
      end
      if (!s_disc && !st) begin
        n_cmp++;
        if (s_pc !== exp_pc) begin
          n_bad++;
          $display("FAIL rnd_order[%0d] pc=%h exp=%h", i, s_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (jmp) exp_pc = tgt;
      p_st    = st;
      p_jmp   = jmp;
      p_instr = s_instr;
      p_pc    = s_pc;
      p_disc  = s_disc;
    end
    n_cmp++;
    if (consumed < 200) begin
      n_bad++;
      $display("FAIL rnd_progress consumed=%0d exp>=200", consumed);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_buf();
    test_redirect_wait();
    test_redirect_gnt_rvalid();
    test_stall_discard();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
